// File: rtl/sysid_arb_pkg.sv
// Shared types and helpers for the two-master sysid read arbiter.
package sysid_arb_pkg;

  localparam int DEFAULT_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RESPOND = 2'd2
  } arb_state_t;

  // Returns the winning master index (0 or 1); only meaningful when a read is pending.
  function automatic logic pick_grant(input logic req0, input logic req1,
                                      input logic last_grant, input logic fixed_priority);
    if (req0 && req1) return fixed_priority ? 1'b0 : ~last_grant;
    return req1 && !req0;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                 count <= '0;
    else if (en && count != '1) count <= count + CNT_W'(1);
  end

endmodule

// File: rtl/sysid_access_arbiter.sv
// Two Avalon-MM masters sharing one zero-latency sysid slave: IDLE -> ISSUE -> RESPOND per read.
module sysid_access_arbiter
  import sysid_arb_pkg::*;
#(
  parameter int FIXED_PRIORITY = 0,
  parameter int DATA_W         = DEFAULT_DATA_W,
  parameter int CNT_W          = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_read,
  input  logic              m0_address,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic              m1_read,
  input  logic              m1_address,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic              s_address,
  input  logic [DATA_W-1:0] s_readdata,
  output logic [CNT_W-1:0]  rd_count0,
  output logic [CNT_W-1:0]  rd_count1
);

  arb_state_t        state;
  logic              grant;
  logic              last_grant;
  logic [DATA_W-1:0] data_q;
  logic              next_grant;

  assign next_grant = pick_grant(m0_read, m1_read, last_grant, FIXED_PRIORITY != 0);

  // s_address doubles as the latched-address register; it is only non-zero during ISSUE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      grant            <= 1'b0;
      last_grant       <= 1'b1;
      data_q           <= '0;
      s_address        <= 1'b0;
      m0_waitrequest   <= 1'b1;
      m1_waitrequest   <= 1'b1;
      m0_readdatavalid <= 1'b0;
      m1_readdatavalid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_read || m1_read) begin
            grant          <= next_grant;
            s_address      <= next_grant ? m1_address : m0_address;
            m0_waitrequest <= next_grant;
            m1_waitrequest <= ~next_grant;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          data_q           <= s_readdata;
          s_address        <= 1'b0;
          m0_waitrequest   <= 1'b1;
          m1_waitrequest   <= 1'b1;
          m0_readdatavalid <= ~grant;
          m1_readdatavalid <= grant;
          state            <= RESPOND;
        end
        RESPOND: begin
          m0_readdatavalid <= 1'b0;
          m1_readdatavalid <= 1'b0;
          last_grant       <= grant;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Both masters see the shared data register; readdatavalid alone says whose it is.
  assign m0_readdata = data_q;
  assign m1_readdata = data_q;

  sat_counter #(.CNT_W(CNT_W)) u_cnt0 (
    .clock (clock),
    .reset (reset),
    .en    (m0_readdatavalid),
    .count (rd_count0)
  );

  sat_counter #(.CNT_W(CNT_W)) u_cnt1 (
    .clock (clock),
    .reset (reset),
    .en    (m1_readdatavalid),
    .count (rd_count1)
  );

endmodule

// File: doc/sysid_access_arbiter.md
SYSID_ACCESS_ARBITER -- requirements
Module: sysid_access_arbiter

Interface
REQ-001 The block SHALL have parameter FIXED_PRIORITY, default 0; 0 selects round-robin arbitration, 1 makes master 0 always win.
REQ-002 The block SHALL have parameter DATA_W, default 32; this is the readdata width.
REQ-003 The block SHALL have parameter CNT_W, default 16; this is the width of each per-master read counter.
REQ-004 Port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: reset, asynchronous and active-high.
REQ-006 Ports m0_read / m1_read, input, 1 each: Avalon-MM read request from master 0 / master 1.
REQ-007 Ports m0_address / m1_address, input, 1 each: requested sysid word (0 = ID, 1 = timestamp).
REQ-008 Ports m0_waitrequest / m1_waitrequest, output, 1 each: high stalls the master; the read is accepted in the cycle this is low while read is high.
REQ-009 Ports m0_readdata / m1_readdata, output, DATA_W each: registered response data.
REQ-010 Ports m0_readdatavalid / m1_readdatavalid, output, 1 each: one-cycle pulse that qualifies readdata.
REQ-011 Port s_address, output, 1: address driven to the shared zero-latency sysid slave.
REQ-012 Port s_readdata, input, DATA_W: combinational response from the sysid slave.
REQ-013 Ports rd_count0 / rd_count1, output, CNT_W each: count of completed reads per master.

Function
REQ-014 The FSM SHALL have states IDLE, ISSUE and RESPOND.
REQ-015 IDLE: with no read asserted, the FSM SHALL stay in IDLE; with any read asserted, it SHALL latch grant and the granted address, then go to ISSUE.
REQ-016 Arbitration, only one requester: that requester SHALL be granted.
REQ-017 Arbitration, both requesting with FIXED_PRIORITY=0: the master not granted last SHALL win.
REQ-018 Arbitration, both requesting with FIXED_PRIORITY=1: master 0 SHALL win.
REQ-019 ISSUE: s_address SHALL equal the latched address, the granted master's waitrequest SHALL be low for exactly this cycle, s_readdata SHALL be captured into the data register, and the FSM SHALL go to RESPOND.
REQ-020 RESPOND: the granted master's readdatavalid SHALL be high for exactly one cycle with the captured data on its readdata; last_grant SHALL update; the FSM SHALL return to IDLE.
REQ-021 Latency: a read is accepted 1 cycle after read is sampled in IDLE, and data is valid 2 cycles after it is sampled.
REQ-022 Throughput: the block SHALL complete at most one read per 3 cycles.
REQ-023 waitrequest SHALL be high for every master in every cycle except the granted master's ISSUE cycle.
REQ-024 The non-granted master's readdatavalid SHALL be 0 at all times.
REQ-025 Both readdata outputs SHALL show the shared data register; only readdatavalid is qualifying.
REQ-026 A master that drops read while waitrequest is high SHALL still be served once already granted; the response is delivered regardless.
REQ-027 s_address SHALL be 0 outside ISSUE.
REQ-028 rd_countN SHALL increment on master N's readdatavalid pulse and saturate at all-ones, with no wrap.
REQ-029 Simultaneous new requests during RESPOND SHALL be ignored until IDLE.

Reset
REQ-030 While reset is high, state SHALL be IDLE and last_grant SHALL be master 1, so master 0 wins the first tie.
REQ-031 While reset is high, all waitrequests SHALL be 1, all readdatavalids 0, readdata 0, s_address 0 and counters 0.
REQ-032 Reset asserted mid-transaction SHALL abort it, with no readdatavalid pulse and no counter increment.
REQ-033 Operation SHALL resume on the first clock edge after reset deasserts.

Structure
REQ-034 The state encoding (IDLE/ISSUE/RESPOND) and the DATA_W default SHALL live in shared package sysid_arb_pkg.
REQ-035 One sub-module, sat_counter (CNT_W, increment enable, saturating), SHALL be instantiated twice.
REQ-036 The arbiter SHALL be a single FSM plus grant/data/address registers.

Verification
REQ-037 Single read: m0_read=1, m0_address=0, s_readdata=32'h524C_5F6B -> m0_waitrequest low in cycle 1, m0_readdatavalid=1 with 32'h524C_5F6B in cycle 2, rd_count0=1.
REQ-038 Tie round-robin: both reads held high for 6 cycles after reset -> grants M0,M1; rd_count0=1, rd_count1=1; m1_address=1 drives s_address=1 in M1's ISSUE cycle.
REQ-039 FIXED_PRIORITY=1, both reads held high for 9 cycles -> M0 served 3 times, M1 never; rd_count1=0.
REQ-040 Saturation: CNT_W=2, 5 M0 reads -> rd_count0 stays 3 after the 3rd read.
REQ-041 Mid-transaction reset: reset pulsed in ISSUE -> no readdatavalid, counters 0, next request is served normally after release.
